// File: rtl/bin2bcd_seq.sv
// ---------------------------------------------------------------------------
// bin2bcd_seq
//
// Sequential binary-to-BCD converter using shift-add-3 (double dabble).
// It accepts an 8-bit unsigned value under a START/DONE handshake and
// produces a registered 3-digit BCD word for the seven-segment display path.
// The result register is written only on the completing edge, so the display
// never sees intermediate shift states.
//
// Handshake: START is sampled only while idle (BUSY low). The accepting
// edge captures BIN. BUSY is then high for exactly ITER cycles. DONE pulses
// for one cycle in the following idle cycle, coinciding with BUSY falling and
// BCD/BLANK being updated. START during a conversion is ignored, not queued.
// A START seen in the DONE cycle is accepted, giving one result per 9 cycles.
//
// Optional feature macro: BIN2BCD_BLANK_EN
//   defined   : BLANK holds leading-zero blank flags computed on completion.
//   undefined : BLANK is tied to 3'b000 and no blank logic exists.
//
// Ports:
//   CLK        in   1   system clock, rising edge
//   RST        in   1   asynchronous active-high reset
//   START      in   1   conversion request, sampled only in IDLE
//   BIN        in   8   unsigned value, captured on the accepting edge
//   BUSY       out  1   high while a conversion is in progress
//   DONE       out  1   one-cycle pulse when BCD has been updated
//   BCD        out  12  [11:8] hundreds, [7:4] tens, [3:0] units
//   BLANK      out  3   per-digit blank flags, same order as BCD
//   DBG_STATE  out  1   current FSM state (0 = IDLE, 1 = CONV)
// ---------------------------------------------------------------------------
module bin2bcd_seq #(
  parameter int ITER = 8
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic [7:0]  BIN,
  output logic        BUSY,
  output logic        DONE,
  output logic [11:0] BCD,
  output logic [2:0]  BLANK,
  output logic        DBG_STATE
);

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_t;

  localparam logic [2:0] LAST_ITER = 3'(ITER - 1);

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  // [19:8] digit scratch (hundreds, tens, units), [7:0] binary shift field
  logic [19:0] work_q, work_d;
  logic [11:0] bcd_q, bcd_d;
  logic        done_q, done_d;

  logic [11:0] adj;
  logic [19:0] shifted;
  logic        last_iter;

  function automatic logic [3:0] add3(input logic [3:0] d);
    return (d >= 4'd5) ? (d + 4'd3) : d;
  endfunction

  // All three corrections use the pre-shift digits in the same cycle.
  always_comb begin
    adj = {add3(work_q[19:16]), add3(work_q[15:12]), add3(work_q[11:8])};
  end

  // The hundreds digit never exceeds 2, so adj[11] is always zero and can be
  // dropped by the shift.
  assign shifted   = {adj[10:0], work_q[7:0], 1'b0};
  assign last_iter = (state_q == CONV) && (cnt_q == LAST_ITER);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      work_q  <= 20'd0;
      bcd_q   <= 12'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      bcd_q   <= bcd_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    bcd_d   = bcd_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (START) begin
          work_d  = {12'd0, BIN};
          cnt_d   = 3'd0;
          state_d = CONV;
        end
      end
      CONV: begin
        work_d = shifted;
        cnt_d  = cnt_q + 3'd1;
        if (last_iter) begin
          bcd_d   = shifted[19:8];
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef BIN2BCD_BLANK_EN
  logic [2:0] blank_q;
  logic       hund_zero;
  logic       tens_zero;

  assign hund_zero = (shifted[19:16] == 4'd0);
  assign tens_zero = (shifted[15:12] == 4'd0);

  // Reset value matches the blank pattern of a zero result.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      blank_q <= 3'b110;
    end else if (last_iter) begin
      blank_q <= {hund_zero, hund_zero & tens_zero, 1'b0};
    end
  end

  assign BLANK = blank_q;
`else
  assign BLANK = 3'b000;
`endif

  assign BUSY      = (state_q == CONV);
  assign DONE      = done_q;
  assign BCD       = bcd_q;
  assign DBG_STATE = state_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
module tb_bin2bcd_seq;

  logic        CLK;
  logic        RST;
  logic        START;
  logic [7:0]  BIN;
  logic        BUSY;
  logic        DONE;
  logic [11:0] BCD;
  logic [2:0]  BLANK;
  logic        DBG_STATE;

  int n_tests;
  int n_fail;

  logic [11:0] exp_q[$];

  // ---------------- clock / reset ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  bin2bcd_seq #(.ITER(8)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .START     (START),
    .BIN       (BIN),
    .BUSY      (BUSY),
    .DONE      (DONE),
    .BCD       (BCD),
    .BLANK     (BLANK),
    .DBG_STATE (DBG_STATE)
  );

  // ---------------- reference model ----------------
  function automatic logic [11:0] ref_bcd(input int v);
    int h, t, u;
    h = v / 100;
    t = (v / 10) % 10;
    u = v % 10;
    return 12'((h << 8) | (t << 4) | u);
  endfunction

  function automatic logic [2:0] ref_blank(input int v);
`ifdef BIN2BCD_BLANK_EN
    logic hz, tz;
    hz = (v < 100);
    tz = (v < 10);
    return {hz, tz, 1'b0};
`else
    return 3'(v & 0);
`endif
  endfunction

  function automatic logic [2:0] reset_blank();
`ifdef BIN2BCD_BLANK_EN
    return 3'b110;
`else
    return 3'b000;
`endif
  endfunction

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called at a negedge. Runs one conversion of v; poke[i] drives START high
  // during busy cycle i (with BIN scrambled) to show it is ignored.
  task automatic do_conv(input int v, input logic [8:0] poke);
    logic [11:0] prev_bcd;
    int busy_bad;
    int bcd_moved;
    int done_early;
    prev_bcd   = BCD;
    busy_bad   = 0;
    bcd_moved  = 0;
    done_early = 0;
    exp_q.push_back(ref_bcd(v));
    START = 1'b1;
    BIN   = 8'(v);
    for (int i = 1; i <= 8; i++) begin
      @(negedge CLK);
      if (BUSY !== 1'b1) busy_bad++;
      if (DONE !== 1'b0) done_early++;
      if (BCD !== prev_bcd) bcd_moved++;
      START = poke[i];
      BIN   = 8'($urandom_range(0, 255));
    end
    START = 1'b0;
    @(negedge CLK);
    check("busy_len", 32'(busy_bad), 32'd0);
    check("done_early", 32'(done_early), 32'd0);
    check("bcd_stable", 32'(bcd_moved), 32'd0);
    check("done_rise", 32'(DONE), 32'd1);
    check("busy_fall", 32'(BUSY), 32'd0);
    check("bcd", 32'(BCD), 32'(exp_q.pop_front()));
    check("blank", 32'(BLANK), 32'(ref_blank(v)));
    @(negedge CLK);
    check("done_pulse", 32'(DONE), 32'd0);
    check("busy_idle", 32'(BUSY), 32'd0);
    check("bcd_hold", 32'(BCD), 32'(ref_bcd(v)));
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_busy"}, 32'(BUSY), 32'd0);
    check({tag, "_done"}, 32'(DONE), 32'd0);
    check({tag, "_bcd"}, 32'(BCD), 32'd0);
    check({tag, "_blank"}, 32'(BLANK), 32'(reset_blank()));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int dir_vals[5];
    int v;
    int c;
    int gap_bad;
    int seen_done;
    n_tests = 0;
    n_fail  = 0;
    dir_vals = '{255, 0, 9, 10, 100};

    RST   = 1'b1;
    START = 1'b0;
    BIN   = 8'd0;
    repeat (3) @(negedge CLK);
    check_reset_vals("rst");
    RST = 1'b0;
    @(negedge CLK);
    check_reset_vals("post_rst");

    // directed values
    foreach (dir_vals[k]) do_conv(dir_vals[k], 9'd0);

    // START pokes at busy cycles 2 and 5 with BIN scrambled
    do_conv(37, 9'b000100100);

    // reset mid-conversion of 128
    START = 1'b1;
    BIN   = 8'd128;
    @(negedge CLK);
    START = 1'b0;
    repeat (3) @(negedge CLK);
    check("pre_abort_busy", 32'(BUSY), 32'd1);
    RST = 1'b1;
    #1;
    check_reset_vals("abort");
    @(negedge CLK);
    RST = 1'b0;
    seen_done = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge CLK);
      if (DONE !== 1'b0 || BUSY !== 1'b0) seen_done++;
    end
    check("abort_no_done", 32'(seen_done), 32'd0);
    do_conv(128, 9'd0);

    // random values
    for (int i = 0; i < 40; i++) begin
      v = int'($urandom_range(0, 255));
      do_conv(v, 9'($urandom_range(0, 255)) & 9'h0FE);
    end

    // START held high, BIN stepping 0..255 on each DONE
    START = 1'b1;
    BIN   = 8'd0;
    gap_bad = 0;
    for (int k = 0; k < 256; k++) begin
      c = 0;
      for (int w = 1; w <= 12; w++) begin
        @(negedge CLK);
        c = w;
        if (DONE === 1'b1) break;
      end
      if (DONE !== 1'b1) begin
        check("stream_timeout", 32'(DONE), 32'd1);
        break;
      end
      if (c != 9) gap_bad++;
      check("stream_bcd", 32'(BCD), 32'(ref_bcd(k)));
      if (k == 255) START = 1'b0;
      else BIN = 8'(k + 1);
    end
    START = 1'b0;
    check("stream_gap", 32'(gap_bad), 32'd0);
    repeat (2) @(negedge CLK);
    check("stream_idle", 32'(BUSY), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
